// File: rtl/fifo_push_arbiter.sv
// Round-robin arbiter sharing one FIFO write port; grant registered one cycle after the IDLE decision, then one dead cycle.
// Backpressure: Full in IDLE diverts to STALL (no push); sustained stall sets sticky Timeout. Optional FIFO_ARB_PRIO0_EN gives requester 0 strict priority.
module fifo_push_arbiter #(
    parameter int N_REQ       = 4,
    parameter int DW          = 4,
    parameter int STALL_LIMIT = 255,
    parameter int CW          = 8
) (
    input  logic                CLK,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*DW-1:0] req_data,
    input  logic                Full,
    output logic                push,
    output logic [DW-1:0]       Data_In,
    output logic [N_REQ-1:0]    gnt,
    output logic                stall,
    output logic                Timeout
);

    localparam int LW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {IDLE, GRANT, STALL} state_t;

    state_t          state;
    logic [LW-1:0]   last;
    logic [LW-1:0]   win;
    logic [CW-1:0]   stall_cnt;

    // Scan from the requester after the last winner, wrapping around.
    always_comb begin : pick
        logic          found;
        logic [LW-1:0] cand;
        win   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = LW'((int'(last) + k) % N_REQ);
            if (!found && req[cand]) begin
                win   = cand;
                found = 1'b1;
            end
        end
`ifdef FIFO_ARB_PRIO0_EN
        if (req[0]) begin
            win = '0;
        end
`endif
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            state     <= IDLE;
            push      <= 1'b0;
            Data_In   <= '0;
            gnt       <= '0;
            stall     <= 1'b0;
            Timeout   <= 1'b0;
            last      <= LW'(N_REQ - 1);
            stall_cnt <= '0;
        end else begin
            push <= 1'b0;
            gnt  <= '0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        if (Full) begin
                            state     <= STALL;
                            stall     <= 1'b1;
                            stall_cnt <= '0;
                        end else begin
                            push    <= 1'b1;
                            Data_In <= req_data[int'(win)*DW +: DW];
                            gnt     <= N_REQ'(1) << win;
                            last    <= win;
                            state   <= GRANT;
                        end
                    end
                end
                // Dead cycle guarantees Full is settled at the next IDLE decision.
                GRANT: begin
                    state <= IDLE;
                end
                STALL: begin
                    if (stall_cnt != CW'(STALL_LIMIT)) begin
                        stall_cnt <= stall_cnt + 1'b1;
                    end else begin
                        Timeout <= 1'b1;
                    end
                    if (!Full) begin
                        state     <= IDLE;
                        stall     <= 1'b0;
                        stall_cnt <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    stall <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Directed table-driven bench for fifo_push_arbiter (N_REQ=4, DW=4, STALL_LIMIT=4).
module tb_fifo_push_arbiter;

`ifdef FIFO_ARB_PRIO0_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [15:0] req_data;
    logic        Full;
    logic        push;
    logic [3:0]  Data_In;
    logic [3:0]  gnt;
    logic        stall;
    logic        Timeout;

    int n_checks = 0;
    int n_pass   = 0;

    fifo_push_arbiter #(.N_REQ(4), .DW(4), .STALL_LIMIT(4), .CW(8)) dut (
        .CLK(CLK), .rst(rst), .req(req), .req_data(req_data), .Full(Full),
        .push(push), .Data_In(Data_In), .gnt(gnt), .stall(stall), .Timeout(Timeout)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0] req;
        logic       full;
        logic       push;
        logic [3:0] gnt;
        logic [3:0] dat;
        logic       stall;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [3:0] r, input logic f, input logic p,
                       input logic [3:0] g, input logic [3:0] d, input logic s);
        vec_t v;
        v.req = r; v.full = f; v.push = p; v.gnt = g; v.dat = d; v.stall = s;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        rst = 1'b1; req = 4'hF; req_data = 16'hC953; Full = 1'b0;

        // Round-robin sweep, requesters dropping after their grant
        add(4'hF, 0, 1, 4'b0001, 4'h3, 0);
        add(4'hE, 0, 0, 4'b0000, 4'h0, 0);
        add(4'hE, 0, 1, 4'b0010, 4'h5, 0);
        add(4'hC, 0, 0, 4'b0000, 4'h0, 0);
        add(4'hC, 0, 1, 4'b0100, 4'h9, 0);
        add(4'h8, 0, 0, 4'b0000, 4'h0, 0);
        add(4'h8, 0, 1, 4'b1000, 4'hC, 0);
        add(4'h0, 0, 0, 4'b0000, 4'h0, 0);
        add(4'h0, 0, 0, 4'b0000, 4'h0, 0);
        // Wrap between requesters 0 and 3
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0 || PRIO) add(4'h9, 0, 1, 4'b0001, 4'h3, 0);
            else                    add(4'h9, 0, 1, 4'b1000, 4'hC, 0);
            add(4'h9, 0, 0, 4'b0000, 4'h0, 0);
        end
        add(4'h0, 0, 0, 4'b0000, 4'h0, 0);
        // Full in IDLE -> STALL, then grant after release
        add(4'h2, 1, 0, 4'b0000, 4'h0, 1);
        add(4'h2, 1, 0, 4'b0000, 4'h0, 1);
        add(4'h2, 0, 0, 4'b0000, 4'h0, 0);
        add(4'h2, 0, 1, 4'b0010, 4'h5, 0);
        add(4'h0, 0, 0, 4'b0000, 4'h0, 0);
        // Full rising during GRANT is only seen by the next IDLE
        add(4'h4, 0, 1, 4'b0100, 4'h9, 0);
        add(4'h4, 1, 0, 4'b0000, 4'h0, 0);
        add(4'h4, 1, 0, 4'b0000, 4'h0, 1);
        add(4'h4, 0, 0, 4'b0000, 4'h0, 0);
        add(4'h4, 0, 1, 4'b0100, 4'h9, 0);
        add(4'h0, 0, 0, 4'b0000, 4'h0, 0);
        // Three requesters held: rotation, or requester 0 always under priority
        for (int i = 0; i < 4; i++) begin
            if (PRIO || i == 0 || i == 3) add(4'h7, 0, 1, 4'b0001, 4'h3, 0);
            else if (i == 1)              add(4'h7, 0, 1, 4'b0010, 4'h5, 0);
            else                          add(4'h7, 0, 1, 4'b0100, 4'h9, 0);
            add(4'h7, 0, 0, 4'b0000, 4'h0, 0);
        end
        add(4'h0, 0, 0, 4'b0000, 4'h0, 0);

        // Reset held two cycles with all requests asserted
        step();
        step();
        chk("rst_push", push, 0);
        chk("rst_gnt", gnt, 0);
        chk("rst_stall", stall, 0);
        chk("rst_timeout", Timeout, 0);
        chk("rst_data", Data_In, 0);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            req  = vecs[i].req;
            Full = vecs[i].full;
            step();
            chk($sformatf("v%0d_push", i), push, vecs[i].push);
            chk($sformatf("v%0d_gnt", i), gnt, vecs[i].gnt);
            chk($sformatf("v%0d_stall", i), stall, vecs[i].stall);
            chk($sformatf("v%0d_timeout", i), Timeout, 0);
            if (vecs[i].push) chk($sformatf("v%0d_data", i), Data_In, vecs[i].dat);
        end

        // Timeout: Full held 10 cycles against a pending request
        req = 4'h1; Full = 1'b1;
        step();
        chk("to_enter_stall", stall, 1);
        step(); step(); step();
        chk("to_early", Timeout, 0);
        for (int i = 0; i < 6; i++) step();
        chk("to_set", Timeout, 1);
        chk("to_stall_held", stall, 1);
        chk("to_cnt_sat", dut.stall_cnt, 4);
        chk("to_no_push", push, 0);
        Full = 1'b0;
        step();
        chk("to_exit_stall", stall, 0);
        chk("to_cnt_clr", dut.stall_cnt, 0);
        chk("to_sticky1", Timeout, 1);
        step();
        chk("to_grant", gnt, 4'b0001);
        chk("to_sticky2", Timeout, 1);

        // Reset mid-operation clears a freshly registered push and Timeout
        step();
        step();
        chk("mid_push_before", push, 1);
        rst = 1'b1;
        step();
        chk("mid_push", push, 0);
        chk("mid_gnt", gnt, 0);
        chk("mid_timeout", Timeout, 0);
        chk("mid_stall", stall, 0);
        rst = 1'b0; req = 4'h0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
